// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider with pipeline stall request
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, rem_n, quo, quo_n, dsr, q_fix, r_fix;
  logic [WIDTH:0]   shifted, diff;
  logic             neg1, neg2, ge, last, load;
  always_comb begin
    neg1       = signed_div_i & opdata1_i[WIDTH-1];
    neg2       = signed_div_i & opdata2_i[WIDTH-1];
    shifted    = {rem, quo[WIDTH-1]};
    diff       = shifted - {1'b0, dsr};
    // A borrow out of the WIDTH+1 bit subtraction means partial_rem < divisor
    ge         = ~diff[WIDTH];
    rem_n      = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_n      = {quo[WIDTH-2:0], ge};
    q_fix      = (neg1 ^ neg2) ? -quo_n : quo_n;
    r_fix      = neg1 ? -rem_n : rem_n;
    last       = cnt == CW'(WIDTH - 1);
    load       = (state == ON) & ~annul_i & last;
    ready_o    = state == END;
    stallreq_o = start_i & ~ready_o & ~annul_i & ~rst;
    state_n    = state;
    case (state)
      FREE:    state_n = (start_i & ~annul_i) ? ((opdata2_i == '0) ? BYZERO : ON) : FREE;
      BYZERO:  state_n = annul_i ? FREE : END;
      ON:      state_n = annul_i ? FREE : (last ? END : ON);
      default: state_n = (start_i & ~annul_i) ? END : FREE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      result_o <= '0;
    end else begin
      state    <= state_n;
      result_o <= load ? {r_fix, q_fix} : ((state_n == END) ? result_o : '0);
      if (state == FREE) begin
        cnt <= '0;
        rem <= '0;
        quo <= neg1 ? -opdata1_i : opdata1_i;
        dsr <= neg2 ? -opdata2_i : opdata2_i;
      end else if (state == ON) begin
        cnt <= cnt + 1'b1;
        rem <= rem_n;
        quo <= quo_n;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of the iterative divider and its stall protocol
module tb_div_unit;
  logic        clk = 0, rst, start, annul, sgn;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready, stallreq;
  int          checks = 0, errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sgn),
    .opdata1_i(op1), .opdata2_i(op2), .result_o(result), .ready_o(ready), .stallreq_o(stallreq)
  );

  always #5 clk = ~clk;

  // Starts a division right after a clock edge; returns cycles to ready (-1 on timeout)
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [63:0] res, output bit stall_ok);
    start = 1; annul = 0; op1 = a; op2 = b; sgn = s;
    #1;
    stall_ok = stallreq === 1'b1;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        lat = c;
        res = result;
        break;
      end
      if (stallreq !== 1'b1) stall_ok = 0;
    end
  endtask

  task automatic release_start();
    start = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 1; annul = 0; sgn = 0; op1 = 100; op2 = 7;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stallreq); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    rst = 0; start = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res; bit ok;
    run_div(32'd100, 32'd7, 1'b0, lat, res, ok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL u_latency got %0d exp 33", lat); end
    checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL u_result got %h exp %h", res, {32'd2, 32'd14}); end
    checks++; if (!ok) begin errors++; $display("FAIL u_stall_busy got 0 exp 1"); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL u_stall_ready got %b exp 0", stallreq); end
    release_start();
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin errors++; $display("FAIL u_release got %b/%h exp 0/0", ready, result); end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; bit ok;
    run_div(32'hFFFF_FFF9, 32'h2, 1'b1, lat, res, ok);
    checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat !== 33) begin errors++; $display("FAIL s_neg_dividend got %h lat %0d exp %h lat 33", res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    release_start();
    run_div(32'h7, 32'hFFFF_FFFE, 1'b1, lat, res, ok);
    checks++; if (res !== {32'h1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL s_neg_divisor got %h exp %h", res, {32'h1, 32'hFFFF_FFFD}); end
    release_start();
    run_div(32'hFFFF_FFF9, 32'h2, 1'b0, lat, res, ok);
    checks++; if (res !== {32'h1, 32'h7FFF_FFFC}) begin errors++; $display("FAIL u_big_dividend got %h exp %h", res, {32'h1, 32'h7FFF_FFFC}); end
    release_start();
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res; bit ok;
    run_div(32'd5, 32'd0, 1'b0, lat, res, ok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dz_latency got %0d exp 2", lat); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL dz_result got %h exp 0", res); end
    checks++; if (stallreq !== 1'b0 || !ok) begin errors++; $display("FAIL dz_stall got %b ok %0d exp 0 ok 1", stallreq, ok); end
    release_start();
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; bit ok; bit seen;
    start = 1; annul = 0; sgn = 0; op1 = 100; op2 = 7;
    repeat (10) @(posedge clk);
    #1; annul = 1; #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL annul_stall got %b exp 0", stallreq); end
    @(posedge clk); #1;
    annul = 0; start = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready !== 1'b0) seen = 1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL annul_ready got 1 exp 0"); end
    run_div(32'd100, 32'd7, 1'b0, lat, res, ok);
    checks++; if (lat !== 33 || res !== {32'd2, 32'd14}) begin errors++; $display("FAIL annul_redo got %h lat %0d exp %h lat 33", res, lat, {32'd2, 32'd14}); end
    release_start();
  endtask

  task automatic test_overflow();
    int lat; logic [63:0] res; bit ok;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res, ok);
    checks++; if (res !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL ovf_signed got %h exp %h", res, {32'h0, 32'h8000_0000}); end
    release_start();
    run_div(32'hFFFF_FFFF, 32'h1, 1'b0, lat, res, ok);
    checks++; if (res !== {32'h0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL ovf_unsigned got %h exp %h", res, {32'h0, 32'hFFFF_FFFF}); end
    release_start();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start = 1; annul = 0; sgn = 0; op1 = 100; op2 = 7;
    repeat (15) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin errors++; $display("FAIL rst_mid got %b/%h exp 0/0", ready, result); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready !== 1'b0) seen = 1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_ready got 1 exp 0"); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res; bit ok;
    run_div(32'd100, 32'd7, 1'b0, lat, res, ok);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin errors++; $display("FAIL hold_end_%0d got %b/%h exp 1/%h", c, ready, result, {32'd2, 32'd14}); end
    end
    release_start();
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin errors++; $display("FAIL hold_release got %b/%h exp 0/0", ready, result); end
    run_div(32'd1000, 32'd33, 1'b0, lat, res, ok);
    checks++; if (lat !== 33 || res !== {32'd10, 32'd30}) begin errors++; $display("FAIL b2b got %h lat %0d exp %h lat 33", res, lat, {32'd10, 32'd30}); end
    release_start();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
